fsm_out_monitor: RTL and testbench

Observer for the 2-bit sequential control FSM's 3-bit `out` code stream. It samples the code on each valid cycle, reconstructs the producer's state, and checks every code and transition against the legal set. On any violation it raises registered error pulses and enters a sticky safe ALARM state, which only an explicit clear handshake releases. It sits directly on the FSM output bus, in parallel with the downstream consumer.

---
 rtl/fsm_mon_pkg.sv | 20 ++
 rtl/fsm_mon_dwell_cnt.sv | 38 +++
 rtl/fsm_out_monitor.sv | 144 ++++++++++++++
 tb/tb_fsm_out_monitor.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/fsm_mon_pkg.sv
// Shared types and helpers for the FSM out-code monitor.
// Codes 0..3 are legal; a code may only repeat or advance by one, wrapping 3->0.
package fsm_mon_pkg;

   localparam int CODE_W  = 3;
   localparam int STATE_W = 2;

   localparam logic [CODE_W-1:0] LEGAL_MAX = 3'd3;

   typedef enum logic [STATE_W-1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      ALARM = 2'd2
   } mon_state_e;

   function automatic logic [1:0] next_code(input logic [1:0] code);
      return code + 2'd1;
   endfunction

endpackage

// File: rtl/fsm_mon_dwell_cnt.sv
// Saturating dwell counter; lim_hit means one more increment reaches MAX.
// Registered count, lim_hit is combinational from the count; no backpressure.
module fsm_mon_dwell_cnt #(
   parameter int MAX = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic lim_hit
);

   localparam int W = (MAX < 1) ? 1 : $clog2(MAX + 1);
   localparam logic [W-1:0] MAX_V = W'(MAX);
   localparam logic [W-1:0] LIM_V = W'(MAX - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != MAX_V)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign lim_hit = (cnt_q >= LIM_V);

endmodule

// File: rtl/fsm_out_monitor.sv
// Checks the control FSM's 3-bit out code stream; violations latch a sticky ALARM left only via clr_req/clr_ack.
// All outputs registered (one cycle after the sample); MON_TIMEOUT_EN adds the dwell timeout check.
module fsm_out_monitor
   import fsm_mon_pkg::*;
#(
   parameter int DWELL_MAX = 15,
   parameter int CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [CODE_W-1:0] in_code,
   input  logic              clr_req,
   output logic              clr_ack,
   output logic [1:0]        mon_state,
   output logic              err_illegal,
   output logic              err_trans,
   output logic              err_timeout,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              alarm
);

   mon_state_e       state_q, state_d;
   logic [1:0]       mon_q, mon_d;
   logic             ill_q, ill_d;
   logic             trn_q, trn_d;
   logic             tmo_q, tmo_d;
   logic             ack_q, ack_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       code_ok;
   logic [1:0] code;
   logic       dwell_clr;
   logic       dwell_inc;
   logic       dwell_lim;

   assign code_ok = (in_code <= LEGAL_MAX);
   assign code    = in_code[1:0];

`ifdef MON_TIMEOUT_EN
   fsm_mon_dwell_cnt #(
      .MAX (DWELL_MAX)
   ) u_dwell (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (dwell_clr),
      .inc     (dwell_inc),
      .lim_hit (dwell_lim)
   );
`else
   logic dwell_unused;
   assign dwell_unused = dwell_clr ^ dwell_inc ^ (DWELL_MAX == 0);
   assign dwell_lim    = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      mon_d     = mon_q;
      ill_d     = 1'b0;
      trn_d     = 1'b0;
      tmo_d     = 1'b0;
      ack_d     = 1'b0;
      dwell_clr = 1'b0;
      dwell_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (!code_ok) begin
                  ill_d   = 1'b1;
                  state_d = ALARM;
               end else begin
                  mon_d     = code;
                  dwell_clr = 1'b1;
                  state_d   = TRACK;
               end
            end
         end
         TRACK: begin
            if (in_valid) begin
               if (!code_ok) begin
                  ill_d   = 1'b1;
                  state_d = ALARM;
               end else if ((code != mon_q) && (code != next_code(mon_q))) begin
                  trn_d   = 1'b1;
                  state_d = ALARM;
               end else if (code == mon_q) begin
                  // Repeat sample: either it reaches the dwell limit or it extends the dwell.
                  if (dwell_lim) begin
                     tmo_d   = 1'b1;
                     state_d = ALARM;
                  end else begin
                     dwell_inc = 1'b1;
                  end
               end else begin
                  mon_d     = code;
                  dwell_clr = 1'b1;
               end
            end
         end
         default: begin
            // ALARM and the unused encoding: samples ignored, only a clear leaves.
            if (clr_req) begin
               ack_d   = 1'b1;
               mon_d   = 2'd0;
               state_d = IDLE;
            end
         end
      endcase

      cnt_d = cnt_q;
      if ((ill_d || trn_d || tmo_d) && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         mon_q   <= 2'd0;
         ill_q   <= 1'b0;
         trn_q   <= 1'b0;
         tmo_q   <= 1'b0;
         ack_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mon_q   <= mon_d;
         ill_q   <= ill_d;
         trn_q   <= trn_d;
         tmo_q   <= tmo_d;
         ack_q   <= ack_d;
         cnt_q   <= cnt_d;
      end
   end

   assign mon_state   = mon_q;
   assign err_illegal = ill_q;
   assign err_trans   = trn_q;
   assign err_timeout = tmo_q;
   assign err_cnt     = cnt_q;
   assign clr_ack     = ack_q;
   assign alarm       = (state_q != IDLE) && (state_q != TRACK);

endmodule

// File: tb/tb_fsm_out_monitor.sv
// Scoreboard bench for fsm_out_monitor (DWELL_MAX=4, CNT_W=2); expectations follow MON_TIMEOUT_EN.
// Stimulus pushes hand-computed expected outputs; a monitor pops one entry per clock and compares.
module tb_fsm_out_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       in_valid = 1'b0;
   logic [2:0] in_code = 3'd0;
   logic       clr_req = 1'b0;
   logic       clr_ack;
   logic [1:0] mon_state;
   logic       err_illegal, err_trans, err_timeout;
   logic [1:0] err_cnt;
   logic       alarm;

   fsm_out_monitor #(
      .DWELL_MAX (4),
      .CNT_W     (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_code     (in_code),
      .clr_req     (clr_req),
      .clr_ack     (clr_ack),
      .mon_state   (mon_state),
      .err_illegal (err_illegal),
      .err_trans   (err_trans),
      .err_timeout (err_timeout),
      .err_cnt     (err_cnt),
      .alarm       (alarm)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] mon;
      logic       il;
      logic       tr;
      logic       to;
      logic [1:0] cnt;
      logic       al;
      logic       ack;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass   = 0;

   function automatic exp_t actual();
      return exp_t'({mon_state, err_illegal, err_trans, err_timeout, err_cnt, alarm, clr_ack});
   endfunction

   task automatic chk(input string nm, input exp_t act, input exp_t exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got mon=%0d il=%b tr=%b to=%b cnt=%0d alarm=%b ack=%b, want mon=%0d il=%b tr=%b to=%b cnt=%0d alarm=%b ack=%b",
                  nm, act.mon, act.il, act.tr, act.to, act.cnt, act.al, act.ack,
                  exp.mon, exp.il, exp.tr, exp.to, exp.cnt, exp.al, exp.ack);
      end
   endtask

   // Drive one cycle of stimulus and queue the outputs expected after the next clk edge.
   task automatic vec(input string nm, input logic v, input logic [2:0] c, input logic clr,
                      input logic [1:0] m, input logic il, input logic tr, input logic to,
                      input logic [1:0] cnt, input logic al, input logic ack);
      @(negedge clk);
      in_valid = v;
      in_code  = c;
      clr_req  = clr;
      exp_q.push_back(exp_t'({m, il, tr, to, cnt, al, ack}));
      name_q.push_back(nm);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_checks++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
         exp_q.delete();
         name_q.delete();
      end
   endtask

   initial begin : monitor
      exp_t  e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            chk(nm, actual(), e);
         end
      end
   end

   initial begin : stim
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset", actual(), exp_t'(9'd0));
      rst_n = 1'b1;

      //   name       v  code  clr  mon il tr to cnt al ack
      vec("seq0",    1, 3'd0, 0,   0,  0, 0, 0, 0,  0, 0);
      vec("seq1",    1, 3'd1, 0,   1,  0, 0, 0, 0,  0, 0);
      vec("seq2",    1, 3'd2, 0,   2,  0, 0, 0, 0,  0, 0);
      vec("seq3",    1, 3'd3, 0,   3,  0, 0, 0, 0,  0, 0);
      vec("wrap30",  1, 3'd0, 0,   0,  0, 0, 0, 0,  0, 0);
      vec("seq1b",   1, 3'd1, 0,   1,  0, 0, 0, 0,  0, 0);
      vec("novalid", 0, 3'd3, 0,   1,  0, 0, 0, 0,  0, 0);
      vec("trans13", 1, 3'd3, 0,   1,  0, 1, 0, 1,  1, 0);
      vec("alm_ign", 1, 3'd2, 0,   1,  0, 0, 0, 1,  1, 0);
      vec("clr_win", 1, 3'd0, 1,   0,  0, 0, 0, 1,  0, 1);
      vec("clr_hd1", 0, 3'd0, 1,   0,  0, 0, 0, 1,  0, 0);
      vec("clr_hd2", 0, 3'd0, 1,   0,  0, 0, 0, 1,  0, 0);
      vec("ill6",    1, 3'd6, 0,   0,  1, 0, 0, 2,  1, 0);
      vec("ill7ign", 1, 3'd7, 0,   0,  0, 0, 0, 2,  1, 0);
      vec("clr2",    0, 3'd0, 1,   0,  0, 0, 0, 2,  0, 1);
      vec("dw0",     1, 3'd2, 0,   2,  0, 0, 0, 2,  0, 0);
      vec("dw1",     1, 3'd2, 0,   2,  0, 0, 0, 2,  0, 0);
      vec("dw2",     1, 3'd2, 0,   2,  0, 0, 0, 2,  0, 0);
      vec("dwhold",  0, 3'd2, 0,   2,  0, 0, 0, 2,  0, 0);
      vec("dw3",     1, 3'd2, 0,   2,  0, 0, 0, 2,  0, 0);
`ifdef MON_TIMEOUT_EN
      vec("timeout", 1, 3'd2, 0,   2,  0, 0, 1, 3,  1, 0);
`else
      vec("dw4",     1, 3'd2, 0,   2,  0, 0, 0, 2,  0, 0);
      for (int i = 0; i < 15; i++) begin
         vec("persist", 1, 3'd2, 0, 2,  0, 0, 0, 2,  0, 0);
      end
      vec("trans20", 1, 3'd0, 0,   2,  0, 1, 0, 3,  1, 0);
`endif
      vec("clr3",    0, 3'd0, 1,   0,  0, 0, 0, 3,  0, 1);
      vec("sat_ill", 1, 3'd5, 0,   0,  1, 0, 0, 3,  1, 0);
      vec("clr4",    0, 3'd0, 1,   0,  0, 0, 0, 3,  0, 1);
      vec("trk1",    1, 3'd1, 0,   1,  0, 0, 0, 3,  0, 0);
      vec("trk2",    1, 3'd2, 0,   2,  0, 0, 0, 3,  0, 0);
      vec("idle_in", 0, 3'd0, 0,   2,  0, 0, 0, 3,  0, 0);
      drain();

      // Reset between clock edges while tracking code 2.
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", actual(), exp_t'(9'd0));
      @(negedge clk);
      rst_n = 1'b1;
      vec("post_rst", 1, 3'd3, 0,  3,  0, 0, 0, 0,  0, 0);
      vec("post_tr",  1, 3'd1, 0,  3,  0, 1, 0, 1,  1, 0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
